// File: rtl/stream_fifo_pkg.sv
// Shared definitions for the stream_fifo elastic buffer.
// Holds default sizing and the {last,data} beat layout.
package stream_fifo_pkg;

   localparam int unsigned LEN_DEF   = 8;
   localparam int unsigned DEPTH_DEF = 4;

   typedef struct packed {
      logic                last;
      logic [LEN_DEF-1:0]  data;
   } beat_t;

endpackage

// File: rtl/stream_fifo_ptr.sv
// Wrapping AW-bit FIFO pointer with increment enable
// and synchronous active-low clear.
module fifo_ptr #(
   parameter int unsigned AW = 2
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_inc,
   output logic [AW-1:0] o_ptr
);

   logic [AW-1:0] r_ptr;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_ptr <= '0;
      end else if (i_inc) begin
         r_ptr <= r_ptr + AW'(1);
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/stream_fifo.sv
// Packet-aware first-word-fall-through FIFO between the adder and sink stages.
// Tracks occupancy and the number of stored last-of-packet beats.
module stream_fifo
   import stream_fifo_pkg::*;
#(
   parameter  int unsigned LEN   = LEN_DEF,
   parameter  int unsigned DEPTH = DEPTH_DEF,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [LEN-1:0] data_in,
   input  logic           valid_in,
   input  logic           last_in,
   output logic           ready_out,
   output logic [LEN-1:0] data,
   output logic           valid,
   output logic           last,
   input  logic           ready,
   output logic [AW:0]    level,
   output logic [AW:0]    pkts
);

   logic [LEN:0]  r_mem [DEPTH];
   logic [AW:0]   r_cnt;
   logic [AW:0]   r_pkt;

   logic [AW-1:0] w_wp;
   logic [AW-1:0] w_rp;
   logic [LEN:0]  w_head;
   logic          w_empty;
   logic          w_full;
   logic          w_wr;
   logic          w_rd;
   logic          w_pkt_in;
   logic          w_pkt_out;

   fifo_ptr #(.AW(AW)) u_wp (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_inc   (w_wr),
      .o_ptr   (w_wp)
   );

   fifo_ptr #(.AW(AW)) u_rp (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_inc   (w_rd),
      .o_ptr   (w_rp)
   );

   assign w_empty   = (r_cnt == '0);
   assign w_full    = (r_cnt == (AW+1)'(DEPTH));
   // ready_out depends only on stored state, never on downstream ready
   assign ready_out = rst & ~w_full;
   assign valid     = rst & ~w_empty;

   assign w_wr      = valid_in & ready_out;
   assign w_rd      = valid & ready;

   assign w_head    = r_mem[w_rp];
   assign data      = w_head[LEN-1:0];
   assign last      = w_head[LEN];

   assign w_pkt_in  = w_wr & last_in;
   assign w_pkt_out = w_rd & w_head[LEN];

   assign level     = r_cnt;
   assign pkts      = r_pkt;

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[w_wp] <= {last_in, data_in};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt <= '0;
      end else begin
         unique case ({w_wr, w_rd})
            2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_pkt <= '0;
      end else begin
         unique case ({w_pkt_in, w_pkt_out})
            2'b10:   r_pkt <= r_pkt + (AW+1)'(1);
            2'b01:   r_pkt <= r_pkt - (AW+1)'(1);
            default: r_pkt <= r_pkt;
         endcase
      end
   end

endmodule

// File: tb/tb_stream_fifo.sv
// Directed and randomized scoreboard bench for stream_fifo.
// Expected beats are queued on write fire and compared on read fire.
module tb_stream_fifo;
   import stream_fifo_pkg::*;

   localparam int unsigned LEN   = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = $clog2(DEPTH);

   logic           clk = 1'b0;
   logic           rst;
   logic [LEN-1:0] data_in;
   logic           valid_in;
   logic           last_in;
   logic           ready_out;
   logic [LEN-1:0] data;
   logic           valid;
   logic           last;
   logic           ready;
   logic [AW:0]    level;
   logic [AW:0]    pkts;

   beat_t sb [$];
   int    n_chk  = 0;
   int    n_fail = 0;
   int    n_rd   = 0;
   logic  wr_fire;
   logic  rd_fire;

   stream_fifo #(.LEN(LEN), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .last_in   (last_in),
      .ready_out (ready_out),
      .data      (data),
      .valid     (valid),
      .last      (last),
      .ready     (ready),
      .level     (level),
      .pkts      (pkts)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: check outputs at the negedge against the model, then update the model at the posedge.
   task automatic tick();
      int    np;
      logic  er;
      logic  ev;
      beat_t hd;
      @(negedge clk);
      np = 0;
      foreach (sb[k]) if (sb[k].last) np++;
      er = rst && (sb.size() < DEPTH);
      ev = rst && (sb.size() != 0);
      chk("ready_out", 32'(ready_out), 32'(er));
      chk("valid", 32'(valid), 32'(ev));
      chk("level", 32'(level), 32'(sb.size()));
      chk("pkts", 32'(pkts), 32'(np));
      if (ev && ready) begin
         hd = sb[0];
         chk("data", 32'(data), 32'(hd.data));
         chk("last", 32'(last), 32'(hd.last));
      end
      wr_fire = valid_in && er;
      rd_fire = ev && ready;
      @(posedge clk);
      if (!rst) begin
         sb.delete();
      end else begin
         if (rd_fire) begin
            void'(sb.pop_front());
            n_rd++;
         end
         if (wr_fire) sb.push_back('{last: last_in, data: data_in});
      end
      #1;
   endtask

   initial begin
      int sent;
      int cycles;

      // Reset held with valid_in asserted
      rst = 1'b0; valid_in = 1'b1; data_in = 8'h5A; last_in = 1'b1; ready = 1'b0;
      repeat (2) tick();
      valid_in = 1'b0;
      rst = 1'b1;
      tick();
      chk("rst_ready_out", 32'(ready_out), 32'd1);

      // Fill with ready low, then drain
      for (int i = 0; i < 4; i++) begin
         valid_in = 1'b1;
         data_in  = 8'(8'h11 * (i + 1));
         last_in  = (i == 3);
         tick();
      end
      valid_in = 1'b0;
      tick();
      chk("full_level", 32'(level), 32'd4);
      chk("full_pkts", 32'(pkts), 32'd1);
      ready = 1'b1;
      n_rd = 0;
      repeat (4) tick();
      chk("drain_reads", 32'(n_rd), 32'd4);
      tick();
      chk("drain_level", 32'(level), 32'd0);

      // Continuous streaming
      n_rd = 0;
      for (int i = 0; i < 20; i++) begin
         valid_in = 1'b1;
         data_in  = 8'(i + 1);
         last_in  = 1'b0;
         tick();
      end
      valid_in = 1'b0;
      tick();
      chk("stream_reads", 32'(n_rd), 32'd20);

      // Full plus simultaneous read
      ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         valid_in = 1'b1;
         data_in  = 8'(8'hB0 + i);
         last_in  = (i == 1);
         tick();
      end
      data_in = 8'hB4; last_in = 1'b1; ready = 1'b1;
      tick();
      chk("full_rd_noacc", 32'(wr_fire), 32'd0);
      tick();
      chk("full_rd_acc", 32'(wr_fire), 32'd1);
      valid_in = 1'b0;
      repeat (5) tick();
      chk("full_rd_empty", 32'(level), 32'd0);

      // Random traffic with wrap-around
      sent = 0;
      cycles = 0;
      valid_in = 1'b0;
      while (sent < 200 && cycles < 5000) begin
         if (!valid_in && $urandom_range(0, 1) == 1) begin
            valid_in = 1'b1;
            data_in  = 8'(sent * 7 + 3);
            last_in  = (sent % 3 == 2);
         end
         ready = ($urandom_range(0, 1) == 1);
         tick();
         if (wr_fire) begin
            sent++;
            valid_in = 1'b0;
         end
         chk("level_max", 32'(level <= 4), 32'd1);
         cycles++;
      end
      chk("rand_sent", 32'(sent), 32'd200);
      valid_in = 1'b0;
      ready = 1'b1;
      repeat (6) tick();
      chk("rand_drained", 32'(level), 32'd0);

      // Mid-operation reset
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         valid_in = 1'b1;
         data_in  = 8'(8'h60 + i);
         last_in  = 1'b1;
         tick();
      end
      valid_in = 1'b0;
      tick();
      chk("pre_rst_level", 32'(level), 32'd3);
      rst = 1'b0; valid_in = 1'b1; data_in = 8'h77; last_in = 1'b1;
      tick();
      rst = 1'b1; valid_in = 1'b0;
      tick();
      chk("post_rst_level", 32'(level), 32'd0);
      chk("post_rst_pkts", 32'(pkts), 32'd0);
      chk("post_rst_valid", 32'(valid), 32'd0);
      valid_in = 1'b1; data_in = 8'hA5; last_in = 1'b0;
      tick();
      valid_in = 1'b0;
      ready = 1'b1;
      @(negedge clk);
      chk("first_after_rst", 32'(data), 32'h0A5);
      @(posedge clk);
      #1;
      sb.delete();
      tick();
      chk("final_level", 32'(level), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
